// File: rtl/dec_pkg.sv
// Shared RV32 decode constants, instruction-type codes and the decoded control bundle.
package dec_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

  localparam logic [3:0] INST_NONE   = 4'd0;
  localparam logic [3:0] INST_LUI    = 4'd1;
  localparam logic [3:0] INST_AUIPC  = 4'd2;
  localparam logic [3:0] INST_JAL    = 4'd3;
  localparam logic [3:0] INST_JALR   = 4'd4;
  localparam logic [3:0] INST_BRANCH = 4'd5;
  localparam logic [3:0] INST_LOAD   = 4'd6;
  localparam logic [3:0] INST_STORE  = 4'd7;
  localparam logic [3:0] INST_IMM    = 4'd8;
  localparam logic [3:0] INST_REG    = 4'd9;
  localparam logic [3:0] INST_SYS    = 4'd10;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [3:0] mem_wbmask;
    logic       is_mem_sign;
    logic [3:0] inst_type;
    logic       ebreak;
    logic       illegal;
  } dec_entry_t;

  // ECALL and EBREAK are the only legal SYSTEM encodings, and both stop intake.
  function automatic logic is_trap(dec_entry_t e);
    return (e.inst_type == INST_SYS) && !e.illegal;
  endfunction

endpackage

// File: rtl/dec_core.sv
// Purely combinational RV32I/E instruction decoder; illegal encodings zero every decoded field.
module dec_core import dec_pkg::*; #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_ID_W = 5
) (
  input  logic [XLEN-1:0]     i_inst,
  output logic [REG_ID_W-1:0] o_rd,
  output logic [REG_ID_W-1:0] o_rs1,
  output logic [REG_ID_W-1:0] o_rs2,
  output logic [XLEN-1:0]     o_imm,
  output dec_entry_t          o_ctrl
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
  logic        w_reg_bad, w_bad;
  dec_entry_t  w_ctrl;

  assign w_opc   = i_inst[6:0];
  assign w_f3    = i_inst[14:12];
  assign w_imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_imm_u = {i_inst[31:12], 12'b0};
  assign w_imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  // Raw index fields are checked regardless of opcode, so RV32E rejects any x16..x31 encoding.
  assign w_reg_bad = ((i_inst[11:7] >> REG_ID_W) != 5'd0) ||
                     ((i_inst[19:15] >> REG_ID_W) != 5'd0) ||
                     ((i_inst[24:20] >> REG_ID_W) != 5'd0);

  always_comb begin
    w_ctrl = '0;
    w_imm  = '0;
    w_bad  = 1'b0;
    case (w_opc)
      OPC_LUI:   begin w_ctrl.inst_type = INST_LUI;   w_imm = w_imm_u; end
      OPC_AUIPC: begin w_ctrl.inst_type = INST_AUIPC; w_imm = w_imm_u; end
      OPC_JAL:   begin w_ctrl.inst_type = INST_JAL;   w_imm = w_imm_j; end
      OPC_JALR:  begin w_ctrl.inst_type = INST_JALR;  w_imm = w_imm_i; end
      OPC_BRANCH: begin
        w_ctrl.inst_type = INST_BRANCH;
        w_imm            = w_imm_b;
        w_bad            = (w_f3 == 3'b010) || (w_f3 == 3'b011);
      end
      OPC_LOAD: begin
        w_ctrl.inst_type   = INST_LOAD;
        w_ctrl.is_mem_sign = !w_f3[2];
        w_imm              = w_imm_i;
        w_bad              = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_ctrl.inst_type = INST_STORE;
        w_imm            = w_imm_s;
        case (w_f3)
          F3_B:    w_ctrl.mem_wbmask = 4'b0001;
          F3_H:    w_ctrl.mem_wbmask = 4'b0011;
          F3_W:    w_ctrl.mem_wbmask = 4'b1111;
          default: w_bad = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        w_ctrl.inst_type = INST_IMM;
        w_ctrl.alu_op    = {i_inst[30] & (w_f3 == F3_SRX), w_f3};
        w_imm            = ((w_f3 == F3_SLL) || (w_f3 == F3_SRX)) ? {27'b0, i_inst[24:20]}
                                                                  : w_imm_i;
      end
      OPC_OP: begin
        w_ctrl.inst_type = INST_REG;
        w_ctrl.alu_op    = {i_inst[30], w_f3};
      end
      OPC_SYSTEM: begin
        w_ctrl.inst_type = INST_SYS;
        if (i_inst[31:7] == 25'h0002000) begin
          w_ctrl.ebreak = 1'b1;
        end else if (i_inst[31:7] != 25'h0) begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase
    if ((i_inst[1:0] != 2'b11) || w_reg_bad) begin
      w_bad = 1'b1;
    end
    if (w_bad) begin
      w_ctrl         = '0;
      w_ctrl.illegal = 1'b1;
      w_imm          = '0;
    end
  end

  assign o_ctrl = w_ctrl;
  assign o_imm  = XLEN'($signed(w_imm));
  assign o_rd   = w_bad ? '0 : i_inst[7 +: REG_ID_W];
  assign o_rs1  = w_bad ? '0 : i_inst[15 +: REG_ID_W];
  assign o_rs2  = w_bad ? '0 : i_inst[20 +: REG_ID_W];

endmodule

// File: rtl/dec_pipe.sv
// Decode stage: dec_core feeding a circular output FIFO, with a RUN/HALT trap state machine.
module dec_pipe import dec_pkg::*; #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_ID_W = 5,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_inst,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [REG_ID_W-1:0] out_rd,
  output logic [REG_ID_W-1:0] out_rs1,
  output logic [REG_ID_W-1:0] out_rs2,
  output logic [XLEN-1:0]     out_imm,
  output logic [3:0]          out_alu_op,
  output logic [3:0]          out_mem_wbmask,
  output logic                out_is_mem_sign,
  output logic [3:0]          out_inst_type,
  output logic                out_ebreak,
  output logic                out_illegal,
  output logic                halted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [0:0] {StRun, StHalt} state_t;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     imm;
    logic [REG_ID_W-1:0] rd;
    logic [REG_ID_W-1:0] rs1;
    logic [REG_ID_W-1:0] rs2;
    dec_entry_t          ctrl;
  } slot_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  slot_t           r_mem [DEPTH];
  slot_t           w_new, w_head;
  logic            w_push, w_pop;

  dec_core #(
    .XLEN     (XLEN),
    .REG_ID_W (REG_ID_W)
  ) u_core (
    .i_inst (in_inst),
    .o_rd   (w_new.rd),
    .o_rs1  (w_new.rs1),
    .o_rs2  (w_new.rs2),
    .o_imm  (w_new.imm),
    .o_ctrl (w_new.ctrl)
  );
  assign w_new.pc = in_pc;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  // Gating with reset keeps any handshake from completing while reset is held.
  assign in_ready  = !reset && (r_state == StRun) && !flush &&
                     ((r_count < CW'(DEPTH)) || w_pop);
  assign w_push    = in_valid && in_ready;
  assign halted    = (r_state == StHalt);

  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = StRun;
    end else if ((r_state == StRun) && w_push && is_trap(w_new.ctrl)) begin
      w_state_next = StHalt;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= StRun;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_push && !w_pop) begin
          r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
          r_count <= r_count - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_new;
    end
  end

  assign w_head          = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_pc          = w_head.pc;
  assign out_imm         = w_head.imm;
  assign out_rd          = w_head.rd;
  assign out_rs1         = w_head.rs1;
  assign out_rs2         = w_head.rs2;
  assign out_alu_op      = w_head.ctrl.alu_op;
  assign out_mem_wbmask  = w_head.ctrl.mem_wbmask;
  assign out_is_mem_sign = w_head.ctrl.is_mem_sign;
  assign out_inst_type   = w_head.ctrl.inst_type;
  assign out_ebreak      = w_head.ctrl.ebreak;
  assign out_illegal     = w_head.ctrl.illegal;

endmodule
